// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and helpers for the UART receive path.
//   S_* : FSM state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
//   PAR_*: parity mode selectors
//   clog2: ceiling log2 for constant width calculations
package uart_pkg;
    localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4;
    localparam int PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2;
    function automatic int clog2(input int v);
        for (int r = 0; r < 31; r++)
            if ((1 << r) >= v) return r;
        return 31;
    endfunction
endpackage

// File: rtl/data_sync.sv
// data_sync: 2-flop synchronizer for an asynchronous 1-bit input.
//   clk     in  system clock
//   reset_n in  synchronous active-low reset
//   d       in  asynchronous input
//   q       out synchronized output
module data_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta;
    // Resetting to 0 keeps a line that is still low after reset from looking idle,
    // so the receiver only arms once it has really seen a high level.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: oversampling UART receiver, 5..9 data bits, optional parity, 1/2 stop bits.
//   clk        in  system clock
//   reset_n    in  synchronous active-low reset
//   baud_tick  in  OVERSAMPLE pulses per bit period
//   rx         in  asynchronous serial input, idle high
//   rx_data    out last received word
//   rx_valid   out one-clk pulse on frame completion
//   parity_err out parity mismatch in last frame
//   frame_err  out a stop bit sampled 0 in last frame
//   break_det  out last frame entirely zero including stop bits
//   busy       out receiver not idle
module uart_rx_ext import uart_pkg::*; #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);
    localparam int SW = clog2(OVERSAMPLE);
    localparam logic [SW-1:0] M_LO = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] M    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] M_HI = SW'(OVERSAMPLE / 2 + 1);

    logic                 rxs, s0, s1, pbit, ferr, ones, armed, maj, px, perr;
    logic [2:0]           state;
    logic [SW-1:0]        scnt;
    logic [3:0]           bcnt;
    logic [DATA_BITS-1:0] shreg;

    data_sync u_sync (.clk(clk), .reset_n(reset_n), .d(rx), .q(rxs));

    assign maj  = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    assign px   = ^shreg ^ pbit;
    assign perr = (PARITY == PAR_ODD) ? ~px : (PARITY == PAR_EVEN) ? px : 1'b0;
    assign busy = state != S_IDLE;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            scnt       <= '0;
            bcnt       <= '0;
            s0         <= 1'b0;
            s1         <= 1'b0;
            shreg      <= '0;
            pbit       <= 1'b0;
            ferr       <= 1'b0;
            ones       <= 1'b0;
            armed      <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (baud_tick) begin
                if (state == S_IDLE) begin
                    // The detecting tick counts as sample 0 of the start bit.
                    scnt <= (!rxs && armed) ? SW'(1) : '0;
                    if (rxs) armed <= 1'b1;
                    else if (armed) state <= S_START;
                end else begin
                    scnt <= scnt + 1'b1;
                    if (scnt == M_LO) s0 <= rxs;
                    if (scnt == M) s1 <= rxs;
                    if (scnt == M_HI) begin
                        case (state)
                            S_START: begin
                                state <= maj ? S_IDLE : S_DATA;
                                bcnt  <= '0;
                                ones  <= 1'b0;
                                ferr  <= 1'b0;
                            end
                            S_DATA: begin
                                shreg <= {maj, shreg[DATA_BITS-1:1]};
                                ones  <= ones | maj;
                                bcnt  <= bcnt + 1'b1;
                                if (bcnt == 4'(DATA_BITS - 1)) begin
                                    bcnt  <= '0;
                                    state <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                                end
                            end
                            S_PARITY: begin
                                pbit  <= maj;
                                ones  <= ones | maj;
                                state <= S_STOP;
                            end
                            default: begin
                                ferr <= ferr | ~maj;
                                ones <= ones | maj;
                                bcnt <= bcnt + 1'b1;
                                // Leave at mid-stop-bit so the next start edge is caught early.
                                if (bcnt == 4'(STOP_BITS - 1)) begin
                                    state      <= S_IDLE;
                                    armed      <= 1'b0;
                                    rx_valid   <= 1'b1;
                                    rx_data    <= shreg;
                                    parity_err <= perr;
                                    frame_err  <= ferr | ~maj;
                                    break_det  <= ~(ones | maj);
                                end
                            end
                        endcase
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: directed scoreboard bench for three receiver configurations.
module tb_uart_rx_ext;
    logic clk = 1'b0, reset_n = 1'b0, baud_tick = 1'b0;
    logic rx_n = 1'b1, rx_e = 1'b1, rx_o = 1'b1;
    logic [7:0] d_n, d_e;
    logic [6:0] d_o;
    logic v_n, v_e, v_o, p_n, p_e, p_o, f_n, f_e, f_o, b_n, b_e, b_o, y_n, y_e, y_o;
    logic pv_n = 1'b0, pv_e = 1'b0, pv_o = 1'b0;
    int checks = 0, errors = 0;

    typedef struct packed {
        logic [8:0] d;
        logic       p;
        logic       f;
        logic       b;
    } exp_t;
    exp_t q_n[$], q_e[$], q_o[$];

    uart_rx_ext #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY(0), .STOP_BITS(1)) u_n (
        .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .rx(rx_n), .rx_data(d_n),
        .rx_valid(v_n), .parity_err(p_n), .frame_err(f_n), .break_det(b_n), .busy(y_n));
    uart_rx_ext #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY(2), .STOP_BITS(1)) u_e (
        .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .rx(rx_e), .rx_data(d_e),
        .rx_valid(v_e), .parity_err(p_e), .frame_err(f_e), .break_det(b_e), .busy(y_e));
    uart_rx_ext #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(2)) u_o (
        .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .rx(rx_o), .rx_data(d_o),
        .rx_valid(v_o), .parity_err(p_o), .frame_err(f_o), .break_det(b_o), .busy(y_o));

    always #5 clk = ~clk;

    initial forever begin
        repeat (3) @(negedge clk);
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp(string t, exp_t e, logic [8:0] d, logic p, logic f, logic b);
        chk({t, "_data"}, d, e.d);
        chk({t, "_parity_err"}, p, e.p);
        chk({t, "_frame_err"}, f, e.f);
        chk({t, "_break_det"}, b, e.b);
    endtask

    always @(negedge clk) begin
        if (v_n) begin
            chk("n_pulse_width", pv_n, 0);
            chk("n_frame_expected", q_n.size() != 0, 1);
            if (q_n.size() != 0) cmp("n", q_n.pop_front(), {1'b0, d_n}, p_n, f_n, b_n);
        end
        if (v_e) begin
            chk("e_pulse_width", pv_e, 0);
            chk("e_frame_expected", q_e.size() != 0, 1);
            if (q_e.size() != 0) cmp("e", q_e.pop_front(), {1'b0, d_e}, p_e, f_e, b_e);
        end
        if (v_o) begin
            chk("o_pulse_width", pv_o, 0);
            chk("o_frame_expected", q_o.size() != 0, 1);
            if (q_o.size() != 0) cmp("o", q_o.pop_front(), {2'b0, d_o}, p_o, f_o, b_o);
        end
        pv_n = v_n;
        pv_e = v_e;
        pv_o = v_o;
    end

    function automatic logic [15:0] mk(logic [8:0] d, int nd, int par, logic flip, logic sv, int ns);
        logic [15:0] r;
        int k;
        r = '1;
        r[0] = 1'b0;
        for (int i = 0; i < nd; i++) r[1 + i] = d[i];
        k = 1 + nd;
        if (par != 0) begin
            r[k] = ((par == 1) ? ~^d : ^d) ^ flip;
            k++;
        end
        for (int s = 0; s < ns; s++) r[k + s] = sv;
        return r;
    endfunction

    task automatic line(int w, logic v);
        if (w == 0) rx_n = v;
        else if (w == 1) rx_e = v;
        else rx_o = v;
    endtask

    task automatic send(int w, logic [15:0] b, int n, int bc, int gb);
        for (int i = 0; i < n; i++) begin
            line(w, b[i]);
            if (i == gb) begin
                repeat (bc / 2 - 2) @(negedge clk);
                line(w, ~b[i]);
                repeat (4) @(negedge clk);
                line(w, b[i]);
                repeat (bc / 2 - 2) @(negedge clk);
            end else begin
                repeat (bc) @(negedge clk);
            end
        end
        line(w, 1'b1);
    endtask

    initial begin
        logic [15:0] b;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("rst_data", d_n, 0);
        chk("rst_valid", v_n, 0);
        chk("rst_parity_err", p_e, 0);
        chk("rst_frame_err", f_n, 0);
        chk("rst_break_det", b_n, 0);
        chk("rst_busy", y_o, 0);

        q_n.push_back(exp_t'{9'h0A5, 1'b0, 1'b0, 1'b0});
        send(0, mk(9'h0A5, 8, 0, 1'b0, 1'b1, 1), 10, 32, -1);
        repeat (64) @(negedge clk);
        chk("n_idle_after_frame", y_n, 0);

        q_e.push_back(exp_t'{9'h037, 1'b0, 1'b0, 1'b0});
        send(1, mk(9'h037, 8, 2, 1'b0, 1'b1, 1), 11, 32, -1);
        repeat (64) @(negedge clk);
        q_e.push_back(exp_t'{9'h037, 1'b1, 1'b0, 1'b0});
        send(1, mk(9'h037, 8, 2, 1'b1, 1'b1, 1), 11, 32, -1);
        repeat (64) @(negedge clk);

        q_n.push_back(exp_t'{9'h05A, 1'b0, 1'b1, 1'b0});
        send(0, mk(9'h05A, 8, 0, 1'b0, 1'b0, 1), 10, 32, -1);
        repeat (64) @(negedge clk);

        q_n.push_back(exp_t'{9'h000, 1'b0, 1'b1, 1'b1});
        rx_n = 1'b0;
        repeat (20 * 32) @(negedge clk);
        chk("break_no_retrigger_busy", y_n, 0);
        rx_n = 1'b1;
        repeat (64) @(negedge clk);

        rx_n = 1'b0;
        repeat (8) @(negedge clk);
        rx_n = 1'b1;
        repeat (32) @(negedge clk);
        chk("glitch_busy_cleared", y_n, 0);
        repeat (32) @(negedge clk);

        q_n.push_back(exp_t'{9'h0A5, 1'b0, 1'b0, 1'b0});
        send(0, mk(9'h0A5, 8, 0, 1'b0, 1'b1, 1), 10, 32, 4);
        repeat (64) @(negedge clk);

        q_o.push_back(exp_t'{9'h041, 1'b0, 1'b0, 1'b0});
        q_o.push_back(exp_t'{9'h07F, 1'b0, 1'b0, 1'b0});
        send(2, mk(9'h041, 7, 1, 1'b0, 1'b1, 2), 11, 64, -1);
        send(2, mk(9'h07F, 7, 1, 1'b0, 1'b1, 2), 11, 64, -1);
        b = mk(9'h055, 7, 1, 1'b0, 1'b1, 2);
        send(2, b, 5, 64, -1);
        rx_o = b[5];
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        rx_o = 1'b1;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("o_rst_data", d_o, 0);
        chk("o_rst_parity_err", p_o, 0);
        chk("o_rst_frame_err", f_o, 0);
        chk("o_rst_break_det", b_o, 0);
        chk("o_rst_busy", y_o, 0);
        chk("o_two_frames_seen", q_o.size(), 0);
        repeat (128) @(negedge clk);
        chk("o_no_third_frame", d_o, 0);

        q_o.push_back(exp_t'{9'h012, 1'b0, 1'b0, 1'b0});
        send(2, mk(9'h012, 7, 1, 1'b0, 1'b1, 2), 11, 64, -1);
        repeat (128) @(negedge clk);

        chk("n_queue_drained", q_n.size(), 0);
        chk("e_queue_drained", q_e.size(), 0);
        chk("o_queue_drained", q_o.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
